// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding, byte-lane constants and fault check for the data-memory responder
package dmem_pkg;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    localparam int WORD_BYTES = 4;
    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_ALL = 4'b1111;
    function automatic logic is_fault(input logic [31:0] addr, input logic [3:0] be, input int unsigned depth);
        return (addr[1:0] != 2'b00) || (be == BE_NONE) || ({2'b00, addr[31:2]} >= depth);
    endfunction
endpackage

// File: rtl/dmem_byte_ram.sv
// dmem_byte_ram: DEPTH_WORDS x 32 RAM with per-lane write enables and registered read data
//   clk   in   clock
//   idx   in   word index
//   we    in   lane write enables (bit i writes byte lane i)
//   wdata in   lane-aligned write data
//   rdata out  word read on the previous edge (old data on a same-edge write)
module dmem_byte_ram import dmem_pkg::*; #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk,
    input  logic [AW-1:0]         idx,
    input  logic [WORD_BYTES-1:0] we,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);
    logic [31:0] mem [DEPTH_WORDS];
    always_ff @(posedge clk) begin
        for (int i = 0; i < WORD_BYTES; i++)
            if (we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        rdata <= mem[idx];
    end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: CPU data-memory responder with valid/ready request/response channels and wait states
//   clk, rst (async, active-low)
//   req_valid/req_ready, req_wr, req_addr, req_wdata, req_be : request channel
//   rsp_valid/rsp_ready, rsp_rdata, rsp_err                  : response channel
//   DMEM_PIPE_EN: when defined, a new request may be accepted in the response handshake cycle
module data_mem_responder import dmem_pkg::*; #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WLAST = 4'(WAIT_CYCLES - 1);
    localparam state_t AFTER = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
    state_t state, state_n;
    logic [3:0] cnt, cnt_n;
    logic rdy_en, accept, enter, wr_q, flt_q, wr_s, flt_s, flt_req;
    logic [AW-1:0] idx_q, idx_s;
    logic [31:0] wdata_q, wdata_s, ram_rdata;
    logic [3:0] be_q, be_s, we;
`ifdef DMEM_PIPE_EN
    assign req_ready = rdy_en & ((state == S_IDLE) | ((state == S_RESP) & rsp_ready));
`else
    assign req_ready = rdy_en & (state == S_IDLE);
`endif
    always_comb begin
        flt_req = is_fault(req_addr, req_be, DEPTH_WORDS);
        accept = req_valid & req_ready;
        // RAM access happens on the edge entering RESP; with no wait states that is the accept edge itself
        enter = (accept & (WAIT_CYCLES == 0)) | ((state == S_WAIT) & (cnt == WLAST));
        wr_s = accept ? req_wr : wr_q;
        flt_s = accept ? flt_req : flt_q;
        idx_s = accept ? req_addr[AW+1:2] : idx_q;
        wdata_s = accept ? req_wdata : wdata_q;
        be_s = accept ? req_be : be_q;
        we = (enter & wr_s & ~flt_s) ? be_s : BE_NONE;
        state_n = accept ? AFTER : enter ? S_RESP : ((state == S_RESP) & rsp_ready) ? S_IDLE : state;
        cnt_n = ((state == S_WAIT) & (cnt != WLAST)) ? cnt + 4'd1 : 4'd0;
        rsp_valid = state == S_RESP;
        rsp_err = rsp_valid & flt_q;
        rsp_rdata = (rsp_valid & ~flt_q & ~wr_q) ? ram_rdata : '0;
    end
    // rdy_en holds req_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt <= '0;
            rdy_en <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            rdy_en <= 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q <= 1'b0;
            flt_q <= 1'b0;
            idx_q <= '0;
            wdata_q <= '0;
            be_q <= '0;
        end else if (accept) begin
            wr_q <= req_wr;
            flt_q <= flt_req;
            idx_q <= req_addr[AW+1:2];
            wdata_q <= req_wdata;
            be_q <= req_be;
        end
    end
    dmem_byte_ram #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_ram (
        .clk(clk),
        .idx(idx_s),
        .we(we),
        .wdata(wdata_s),
        .rdata(ram_rdata)
    );
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: model-checked directed test of data_mem_responder (WAIT_CYCLES=2) plus a zero-wait throughput instance
module tb_data_mem_responder;
    localparam int DEPTH = 1024;
    localparam int W = 2;
`ifdef DMEM_PIPE_EN
    localparam bit PIPE = 1'b1;
    localparam int TPUT = 5;
`else
    localparam bit PIPE = 1'b0;
    localparam int TPUT = 8;
`endif
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    logic req_valid = 1'b0, req_wr = 1'b0, rsp_ready = 1'b1;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0] req_be = '0;
    logic req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic r1_valid = 1'b0;
    logic [31:0] r1_addr = '0;
    logic r1_ready, rsp1_valid, rsp1_err;
    logic [31:0] rsp1_rdata;
    int checks = 0, errors = 0;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) u0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );
    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u1 (
        .clk(clk), .rst(rst), .req_valid(r1_valid), .req_ready(r1_ready), .req_wr(1'b0),
        .req_addr(r1_addr), .req_wdata(32'h0), .req_be(4'hF), .rsp_valid(rsp1_valid),
        .rsp_ready(1'b1), .rsp_rdata(rsp1_rdata), .rsp_err(rsp1_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: a request accepted before cycle k is answered from cycle k+W+1,
    // and its memory effect is applied at that moment (so a reset before then drops it).
    typedef struct {
        int due; bit wr; int idx; logic [31:0] wd; logic [3:0] be; bit flt; bit done; logic [31:0] rd;
    } txn_t;
    txn_t q[$];
    logic [31:0] mm [DEPTH];
    bit ed = 1'b0;
    int cyc = 0;
    always @(posedge clk or negedge rst) ed <= rst;
    always @(negedge clk) begin
        txn_t t;
        bit ev, er;
        if (!rst) begin
            q.delete();
            chk("rst_req_ready", 32'(req_ready), 0);
            chk("rst_rsp_valid", 32'(rsp_valid), 0);
            chk("rst_rsp_err", 32'(rsp_err), 0);
            chk("rst_rsp_rdata", rsp_rdata, 0);
        end else begin
            if (q.size() > 0 && !q[0].done && cyc >= q[0].due) begin
                t = q[0];
                if (!t.flt && t.wr)
                    for (int i = 0; i < 4; i++) if (t.be[i]) mm[t.idx][8*i +: 8] = t.wd[8*i +: 8];
                t.rd = (t.flt || t.wr) ? 32'h0 : mm[t.idx];
                t.done = 1'b1;
                q[0] = t;
            end
            ev = q.size() > 0 && q[0].done;
            er = ed && (q.size() == 0 || (PIPE && ev && rsp_ready));
            chk("req_ready", 32'(req_ready), 32'(er));
            chk("rsp_valid", 32'(rsp_valid), 32'(ev));
            if (ev) begin
                chk("rsp_err", 32'(rsp_err), 32'(q[0].flt));
                chk("rsp_rdata", rsp_rdata, q[0].rd);
                if (rsp_ready) void'(q.pop_front());
            end
            if (req_valid && er) begin
                t.due = cyc + W + 1;
                t.wr = req_wr;
                t.idx = int'(req_addr / 4);
                t.wd = req_wdata;
                t.be = req_be;
                t.flt = (req_addr % 4 != 0) || (req_be == 4'h0) || (req_addr / 4 >= DEPTH);
                t.done = 1'b0;
                t.rd = '0;
                q.push_back(t);
            end
        end
        cyc++;
    end

    task automatic send(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        bit ok = 1'b0;
        req_wr = wr; req_addr = a; req_wdata = d; req_be = b; req_valid = 1'b1;
        for (int n = 0; n < 30 && !ok; n++) begin
            @(negedge clk);
            ok = req_ready;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("accept", 32'(ok), 1);
    endtask

    task automatic get(output logic [31:0] rd, output logic er, output int lat);
        bit ok = 1'b0;
        rsp_ready = 1'b1; lat = 0; rd = '0; er = 1'b0;
        for (int n = 0; n < 30 && !ok; n++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) begin
                ok = 1'b1; rd = rsp_rdata; er = rsp_err;
            end
        end
        @(posedge clk); #1;
        chk("response", 32'(ok), 1);
    endtask

    initial begin
        logic [31:0] rd;
        logic er;
        int lat, acc, rs, k0, kl;
        bit seen;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        // 1: store then load, latency W+1
        send(1, 32'h10, 32'hDEADBEEF, 4'hF); get(rd, er, lat);
        chk("t1_latency", 32'(lat), 3);
        chk("t1_store_err", 32'(er), 0);
        chk("t1_store_rdata", rd, 0);
        send(0, 32'h10, 32'h0, 4'hF); get(rd, er, lat);
        chk("t1_load", rd, 32'hDEADBEEF);
        // 2: byte lanes
        send(1, 32'h20, 32'h11223344, 4'hF); get(rd, er, lat);
        send(1, 32'h20, 32'hAABBCCDD, 4'b0101); get(rd, er, lat);
        send(0, 32'h20, 32'h0, 4'b0000 | 4'b0010); get(rd, er, lat);
        chk("t2_lanes", rd, 32'h11BB33DD);
        // 3: faults leave word 0 untouched
        send(1, 32'h0, 32'hCAFEF00D, 4'hF); get(rd, er, lat);
        send(0, 32'h22, 32'h0, 4'hF); get(rd, er, lat);
        chk("t3_misalign_err", 32'(er), 1);
        chk("t3_misalign_rdata", rd, 0);
        send(1, 32'h0, 32'h01020304, 4'h0); get(rd, er, lat);
        chk("t3_be0_err", 32'(er), 1);
        send(1, 32'(4 * DEPTH), 32'h12345678, 4'hF); get(rd, er, lat);
        chk("t3_range_err", 32'(er), 1);
        send(0, 32'h0, 32'h0, 4'hF); get(rd, er, lat);
        chk("t3_word0", rd, 32'hCAFEF00D);
        chk("t3_word0_err", 32'(er), 0);
        // 4: backpressure
        rsp_ready = 1'b0;
        send(0, 32'h10, 32'h0, 4'hF);
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            seen = rsp_valid;
        end
        chk("t4_reach_resp", 32'(seen), 1);
        @(posedge clk); #1;
        req_wr = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_be = 4'hF; req_valid = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("t4_hold_valid", 32'(rsp_valid), 1);
            chk("t4_hold_rdata", rsp_rdata, 32'hDEADBEEF);
            chk("t4_hold_ready", 32'(req_ready), 0);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        get(rd, er, lat);
        chk("t4_rdata", rd, 32'hDEADBEEF);
        send(0, 32'h10, 32'h0, 4'hF); get(rd, er, lat);
        chk("t4_no_store", rd, 32'hDEADBEEF);
        // 5: reset mid-operation drops a pending store
        send(1, 32'h30, 32'h0, 4'hF); get(rd, er, lat);
        send(1, 32'h30, 32'h55, 4'hF);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        send(0, 32'h30, 32'h0, 4'hF); get(rd, er, lat);
        chk("t5_dropped", rd, 32'h0);
        // 6: throughput on the zero-wait instance
        acc = 0; rs = 0; k0 = -1; kl = -1;
        r1_addr = '0; r1_valid = 1'b1;
        for (int k = 0; k < 40 && rs < 4; k++) begin
            @(negedge clk);
            if (r1_valid && r1_ready) begin
                if (k0 < 0) k0 = k;
                acc++;
            end
            if (rsp1_valid) begin
                rs++;
                chk("t6_err", 32'(rsp1_err), 0);
                if (rs == 4) kl = k;
            end
            @(posedge clk); #1;
            if (acc == 4) r1_valid = 1'b0;
            r1_addr = 32'(acc * 4);
        end
        chk("t6_responses", 32'(rs), 4);
        chk("t6_cycles", 32'(kl - k0 + 1), 32'(TPUT));
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
